traffic_phase_arbiter: RTL and testbench

- Round-robin scheduler that shares the intersection among N_PHASE conflicting approach phases (e.g. ew_str, ew_left, ns, pedestrian).
- Latches sensor requests and grants exactly one phase green at a time.
- Enforces minimum/maximum green, yellow and all-red clearance intervals.
- Drives the per-phase light codes for the intersection top level.

---
 rtl/traffic_phase_arbiter.sv | 162 ++++++++++++++++
 tb/tb_traffic_phase_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_arbiter.sv
// Round-robin green-phase scheduler for an intersection: latches sensor requests,
// serves one phase at a time and sequences green, yellow and all-red clearance.
module traffic_phase_arbiter #(
  parameter int N_PHASE   = 4,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_PHASE-1:0]     req,
  input  logic                   hold,
  output logic [2*N_PHASE-1:0]   lights,
  output logic [N_PHASE-1:0]     grant,
  output logic [N_PHASE-1:0]     pending,
  output logic                   busy
);

  localparam int IDX_W    = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
  localparam int CTR_TOP0 = (MAX_GREEN > YELLOW) ? MAX_GREEN : YELLOW;
  localparam int CTR_TOP  = (CTR_TOP0 > ALL_RED) ? CTR_TOP0 : ALL_RED;
  localparam int CTR_W    = (CTR_TOP > 0) ? $clog2(CTR_TOP + 1) : 1;

  localparam logic [CTR_W-1:0] MIN_G_LAST = CTR_W'(MIN_GREEN - 1);
  localparam logic [CTR_W-1:0] MAX_G_LAST = CTR_W'(MAX_GREEN - 1);
  localparam logic [CTR_W-1:0] YEL_LAST   = CTR_W'(YELLOW - 1);
  localparam logic [CTR_W-1:0] RED_LAST   = CTR_W'(ALL_RED - 1);
  localparam logic [CTR_W-1:0] CTR_ONE    = CTR_W'(1);
  localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(N_PHASE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CTR_W-1:0]   ctr_reg, ctr_next;
  logic [IDX_W-1:0]   cur_reg, cur_next;
  logic [IDX_W-1:0]   last_reg, last_next;
  logic [N_PHASE-1:0] pending_reg, pending_next;

  logic [N_PHASE-1:0] eff;
  logic [N_PHASE-1:0] others;
  logic [N_PHASE-1:0] cur_onehot;
  logic [N_PHASE-1:0] sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               start_green;
  logic               in_service;

  assign eff        = pending_reg | req;
  assign others     = eff & ~cur_onehot;
  assign in_service = (state_reg == ST_GREEN) || (state_reg == ST_YELLOW);

  // Rotating priority search: the phase after the last-granted one wins first.
  always_comb begin
    int  p;
    logic found;
    sel_idx = last_reg;
    found   = 1'b0;
    p       = 0;
    for (int k = 1; k <= N_PHASE; k++) begin
      p = (int'(last_reg) + k) % N_PHASE;
      if (!found && eff[p[IDX_W-1:0]]) begin
        sel_idx = p[IDX_W-1:0];
        found   = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_PHASE; gi++) begin : g_phase
      assign cur_onehot[gi] = (cur_reg == IDX_W'(gi));
      assign sel_onehot[gi] = (sel_idx == IDX_W'(gi));
      assign grant[gi]      = cur_onehot[gi] & in_service;
      assign lights[2*gi +: 2] =
        !cur_onehot[gi]            ? 2'b00 :
        (state_reg == ST_GREEN)    ? 2'b10 :
        (state_reg == ST_YELLOW)   ? 2'b01 : 2'b00;
    end
  endgenerate

  assign busy    = (state_reg != ST_IDLE);
  assign pending = pending_reg;

  always_comb begin
    state_next  = state_reg;
    ctr_next    = ctr_reg;
    cur_next    = cur_reg;
    last_next   = last_reg;
    start_green = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if ((eff != '0) && !hold) start_green = 1'b1;
      end
      ST_GREEN: begin
        // Gap-out once minimum green is served, max-out only when someone else waits.
        if (((ctr_reg >= MIN_G_LAST) && !req[cur_reg]) ||
            ((others != '0) && (ctr_reg == MAX_G_LAST))) begin
          state_next = ST_YELLOW;
          ctr_next   = '0;
        end else if (ctr_reg < MAX_G_LAST) begin
          ctr_next = ctr_reg + CTR_ONE;
        end
      end
      ST_YELLOW: begin
        if (ctr_reg == YEL_LAST) begin
          state_next = ST_CLEAR;
          ctr_next   = '0;
        end else begin
          ctr_next = ctr_reg + CTR_ONE;
        end
      end
      ST_CLEAR: begin
        if (ctr_reg == RED_LAST) begin
          ctr_next = '0;
          if ((eff != '0) && !hold) start_green = 1'b1;
          else                      state_next  = ST_IDLE;
        end else begin
          ctr_next = ctr_reg + CTR_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        ctr_next   = '0;
      end
    endcase

    if (start_green) begin
      state_next = ST_GREEN;
      cur_next   = sel_idx;
      last_next  = sel_idx;
      ctr_next   = '0;
    end
  end

  // The served phase's own sensor is ignored while it holds the road; clear beats set.
  always_comb begin
    pending_next = (pending_reg | (req & ~(in_service ? cur_onehot : '0)))
                 & ~(start_green ? sel_onehot : '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      ctr_reg     <= '0;
      cur_reg     <= '0;
      last_reg    <= LAST_RST;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ctr_reg     <= ctr_next;
      cur_reg     <= cur_next;
      last_reg    <= last_next;
      pending_reg <= pending_next;
    end
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Scoreboard bench for traffic_phase_arbiter: tests push expected phase services,
// a negedge monitor measures each observed service and compares it on completion.
module tb_traffic_phase_arbiter;

  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   req;
  logic            hold;
  logic [2*NP-1:0] lights;
  logic [NP-1:0]   grant;
  logic [NP-1:0]   pending;
  logic            busy;

  typedef struct {
    int ph;
    int g;
    int y;
    int r;
  } svc_t;

  svc_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   mon_state = 0;  // 0 none, 1 green, 2 yellow, 3 all-red
  int   mon_ph    = 0;
  int   mon_g     = 0;
  int   mon_y     = 0;
  int   mon_r     = 0;

  traffic_phase_arbiter #(
    .N_PHASE(NP), .MIN_GREEN(5), .MAX_GREEN(10), .YELLOW(2), .ALL_RED(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .hold(hold),
    .lights(lights), .grant(grant), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  // Service monitor and safety invariants.
  always @(negedge clk) begin : monitor
    int   obs;
    int   obs_ph;
    int   nonred;
    bit   ending;
    svc_t e;
    if (!reset) begin
      mon_state = 0;
    end else begin
      obs_ph = 0;
      nonred = 0;
      for (int i = 0; i < NP; i++) begin
        if (grant[i]) obs_ph = i;
        if (lights[2*i +: 2] != 2'b00) nonred++;
      end
      n_checks++;
      if (nonred > 1 || !$onehot0(grant) || ((grant == '0) != (nonred == 0))) begin
        n_fail++;
        $display("FAIL invariant: got lights=%b grant=%b, required <=1 non-red phase matching grant", lights, grant);
      end
      if (grant == '0)                       obs = busy ? 3 : 0;
      else if (lights[2*obs_ph +: 2] == 2'b10) obs = 1;
      else if (lights[2*obs_ph +: 2] == 2'b01) obs = 2;
      else                                   obs = 3;
      ending = (mon_state != 0) &&
               ((obs == 0) || ((obs == 1) && ((mon_state != 1) || (obs_ph != mon_ph))));
      if (ending) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL service_unexpected: got phase %0d g=%0d y=%0d r=%0d, required none",
                   mon_ph, mon_g, mon_y, mon_r);
        end else begin
          e = exp_q.pop_front();
          if (mon_ph !== e.ph || mon_g !== e.g || mon_y !== e.y || mon_r !== e.r) begin
            n_fail++;
            $display("FAIL service: got phase %0d g=%0d y=%0d r=%0d, required phase %0d g=%0d y=%0d r=%0d",
                     mon_ph, mon_g, mon_y, mon_r, e.ph, e.g, e.y, e.r);
          end else begin
            $display("service phase %0d green=%0d yellow=%0d red=%0d ok", mon_ph, mon_g, mon_y, mon_r);
          end
        end
      end
      case (obs)
        0: mon_state = 0;
        1: begin
          if (ending || mon_state == 0) begin
            mon_ph = obs_ph; mon_g = 1; mon_y = 0; mon_r = 0;
          end else begin
            mon_g++;
          end
          mon_state = 1;
        end
        2: begin mon_y++; mon_state = 2; end
        default: begin mon_r++; mon_state = 3; end
      endcase
    end
  end

  task automatic wait_idle(output bit timed_out);
    int n = 0;
    while ((busy || grant != '0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    timed_out = (busy || grant != '0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (lights !== '0)  begin n_fail++; $display("FAIL reset_lights: got %b, required 0", lights); end
    n_checks++; if (grant !== '0)   begin n_fail++; $display("FAIL reset_grant: got %b, required 0", grant); end
    n_checks++; if (pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %b, required 0", pending); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || pending !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b pending=%b, required 0/0", busy, pending);
    end
    $display("reset checks done");
  endtask

  task automatic test_single_pulse();
    bit to;
    exp_q.push_back(svc_t'{0, 5, 2, 1});
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL pulse_pending: got %b, required 0000", pending); end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL pulse_timeout: got busy=%b, required idle", busy); end
    n_checks++; if (pending !== '0 || grant !== '0 || busy !== 1'b0 || lights !== '0) begin
      n_fail++; $display("FAIL pulse_end: got pending=%b grant=%b busy=%b lights=%b, required all 0", pending, grant, busy, lights);
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pulse_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_green_extend();
    bit to;
    exp_q.push_back(svc_t'{2, 20, 2, 1});
    req = 4'b0100;
    repeat (10) @(negedge clk);
    n_checks++; if (grant !== 4'b0100 || lights !== 8'b0010_0000) begin
      n_fail++; $display("FAIL extend_mid: got grant=%b lights=%b, required 0100/00100000", grant, lights);
    end
    repeat (10) @(negedge clk);
    req = 4'b0000;
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL extend_timeout: got busy=%b, required idle", busy); end
    exp_q.push_back(svc_t'{2, 5, 2, 1});
    req = 4'b0100;
    repeat (2) @(negedge clk);
    req = 4'b0000;
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL short_timeout: got busy=%b, required idle", busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL extend_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_two_phase();
    bit to;
    exp_q.push_back(svc_t'{0, 10, 2, 1});
    exp_q.push_back(svc_t'{2, 10, 2, 1});
    exp_q.push_back(svc_t'{0, 10, 2, 1});
    exp_q.push_back(svc_t'{2, 5, 2, 1});  // served from the latched request alone
    req = 4'b0101;
    repeat (39) @(negedge clk);
    req = 4'b0000;
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL two_timeout: got busy=%b, required idle", busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL two_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_all_four();
    bit to;
    logic [3:0] exp_p;
    exp_q.push_back(svc_t'{3, 5, 2, 1});
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL four_pre_timeout: got busy=%b, required idle", busy); end
    for (int k = 0; k < 4; k++) exp_q.push_back(svc_t'{k, 5, 2, 1});
    req = 4'b1111;
    @(negedge clk);
    req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      exp_p = 4'(14 << k);
      n_checks++; if (pending !== exp_p) begin
        n_fail++; $display("FAIL four_pending_%0d: got %b, required %b", k, pending, exp_p);
      end
      if (k < 3) repeat (8) @(negedge clk);
    end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL four_timeout: got busy=%b, required idle", busy); end
    exp_q.push_back(svc_t'{1, 5, 2, 1});
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    wait_idle(to);
    exp_q.push_back(svc_t'{3, 5, 2, 1});
    exp_q.push_back(svc_t'{0, 5, 2, 1});
    req = 4'b1001;
    @(negedge clk);
    req = 4'b0000;
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL rotate_first: got grant=%b, required 1000", grant); end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rotate_timeout: got busy=%b, required idle", busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL four_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_hold();
    bit to;
    exp_q.push_back(svc_t'{0, 5, 2, 1});
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    hold = 1'b1;
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL hold_timeout: got busy=%b, required idle", busy); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (busy !== 1'b0 || grant !== '0 || lights !== '0 || pending !== 4'b0010) begin
        n_fail++; $display("FAIL hold_idle_%0d: got busy=%b grant=%b lights=%b pending=%b, required 0/0/0/0010", k, busy, grant, lights, pending);
      end
      @(negedge clk);
    end
    exp_q.push_back(svc_t'{1, 5, 2, 1});
    hold = 1'b0;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0010 || lights !== 8'b0000_1000) begin
      n_fail++; $display("FAIL hold_release: got grant=%b lights=%b, required 0010/00001000", grant, lights);
    end
    wait_idle(to);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL hold_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    req = 4'b0101;
    repeat (3) @(negedge clk);
    n_checks++; if (grant !== 4'b0100 || pending !== 4'b0001) begin
      n_fail++; $display("FAIL mid_before: got grant=%b pending=%b, required 0100/0001", grant, pending);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (lights !== '0 || grant !== '0 || pending !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: got lights=%b grant=%b pending=%b busy=%b, required all 0", lights, grant, pending, busy);
    end
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(svc_t'{1, 5, 2, 1});
    exp_q.push_back(svc_t'{3, 5, 2, 1});
    reset = 1'b1;
    req   = 4'b1010;
    @(negedge clk);
    req = 4'b0000;
    n_checks++; if (grant !== 4'b0010 || pending !== 4'b1000) begin
      n_fail++; $display("FAIL mid_after: got grant=%b pending=%b, required 0010/1000", grant, pending);
    end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL mid_timeout: got busy=%b, required idle", busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    hold  = 1'b0;
    test_reset();
    test_single_pulse();
    test_green_extend();
    test_two_phase();
    test_all_four();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
